// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter: registered one-hot grants, burst-aware grant locking,
// and tracking of the address-phase and data-phase bus owners.
module ahb_arbiter #(
   parameter int DEFAULT_MASTER = 1,
   parameter bit RR_EN          = 1'b1
) (
   input  logic       hclk,
   input  logic       hresetn,
   input  logic       hbusreq_m1,
   input  logic       hbusreq_m2,
   input  logic [1:0] htrans,
   input  logic [2:0] hburst,
   input  logic       hready,
   input  logic [1:0] hresp,
   output logic       hgrant_m1,
   output logic       hgrant_m2,
   output logic [1:0] hmaster,
   output logic [1:0] hmaster_data
);

   localparam logic [1:0] DEF_IDX = (DEFAULT_MASTER == 2) ? 2'd2 : 2'd1;
   localparam logic       DEF_M2  = (DEFAULT_MASTER == 2);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BU_INCR   = 3'b001;

   typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [4:0] beats_left, beats_left_nxt;
   logic [4:0] len;
   logic       gnt_m1, gnt_m2, gnt_m1_nxt, gnt_m2_nxt;
   logic [1:0] hmaster_q, hmaster_data_q;
   logic       acc_nonseq, acc_seq, resp_err;
   logic       owner_req, incr_lock, arb_en, win_m2;

   // SINGLE and INCR count as one beat; fixed bursts use hburst[2:1] only.
   function automatic logic [4:0] burst_len(input logic [1:0] kind);
      case (kind)
         2'b00:   burst_len = 5'd1;
         2'b01:   burst_len = 5'd4;
         2'b10:   burst_len = 5'd8;
         default: burst_len = 5'd16;
      endcase
   endfunction

   always_comb begin
      acc_nonseq     = hready && (htrans == TR_NONSEQ);
      acc_seq        = hready && (htrans == TR_SEQ);
      resp_err       = (hresp != 2'b00);
      len            = burst_len(hburst[2:1]);

      beats_left_nxt = beats_left;
      if (acc_nonseq)
         beats_left_nxt = len - 5'd1;
      else if (acc_seq && (beats_left != 5'd0))
         beats_left_nxt = beats_left - 5'd1;

      // An error response wins over any transition, so the exit happens once.
      state_nxt = state;
      case (state)
         OPEN:    if (acc_nonseq && (len > 5'd1) && !resp_err) state_nxt = LOCKED;
         LOCKED:  if (resp_err || (acc_seq && (beats_left <= 5'd1))) state_nxt = OPEN;
         default: state_nxt = OPEN;
      endcase
   end

   always_comb begin
      owner_req  = (hmaster_q == 2'd2) ? hbusreq_m2 : hbusreq_m1;
      incr_lock  = (hburst == BU_INCR) && (htrans != TR_IDLE) && owner_req;
      arb_en     = hready && (state_nxt == OPEN) && !incr_lock;

      win_m2     = gnt_m2;
      gnt_m1_nxt = gnt_m1;
      gnt_m2_nxt = gnt_m2;
      if (arb_en) begin
         if (hbusreq_m1 && hbusreq_m2)
            win_m2 = RR_EN ? (hmaster_q != 2'd2) : 1'b0;
         else if (hbusreq_m1)
            win_m2 = 1'b0;
         else if (hbusreq_m2)
            win_m2 = 1'b1;
         else
            win_m2 = DEF_M2;
         gnt_m1_nxt = !win_m2;
         gnt_m2_nxt = win_m2;
      end
   end

   // Owners advance only on ready edges; data owner trails the address owner.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state          <= OPEN;
         beats_left     <= 5'd0;
         gnt_m1         <= !DEF_M2;
         gnt_m2         <= DEF_M2;
         hmaster_q      <= DEF_IDX;
         hmaster_data_q <= DEF_IDX;
      end else begin
         state      <= state_nxt;
         beats_left <= beats_left_nxt;
         gnt_m1     <= gnt_m1_nxt;
         gnt_m2     <= gnt_m2_nxt;
         if (hready) begin
            hmaster_q      <= gnt_m2 ? 2'd2 : 2'd1;
            hmaster_data_q <= hmaster_q;
         end
      end
   end

   assign hgrant_m1    = gnt_m1;
   assign hgrant_m2    = gnt_m2;
   assign hmaster      = hmaster_q;
   assign hmaster_data = hmaster_data_q;

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Two-master AHB bus arbiter that sequences ownership of the shared address/data path between master 1 and master 2 ahead of the slave decoder and the `ahb_ram` slaves. It samples bus requests, grants exactly one master at a time, and holds each grant across fixed-length bursts. It tracks the address-phase owner and the data-phase owner that steer the bus multiplexers. One master is always granted: the bus is parked on a default master when nobody requests.

## Interface
Parameters:
- `DEFAULT_MASTER`, 1: parking master when no request is active. Legal values are 1 or 2.
- `RR_EN`, 1: 1 selects round-robin arbitration; 0 selects fixed priority with master 1 highest.

Ports:
- `hclk` in 1: the single clock.
- `hresetn` in 1: reset, synchronous and active-low.
- `hbusreq_m1`, `hbusreq_m2` in 1: bus requests from the two masters.
- `htrans` in 2: muxed address-phase transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- `hburst` in 3: muxed burst type (SINGLE=000, INCR=001, 4-beat=01x, 8-beat=10x, 16-beat=11x).
- `hready` in 1: bus-level ready.
- `hresp` in 2: bus-level response (OKAY=00).
- `hgrant_m1`, `hgrant_m2` out 1: registered one-hot grants.
- `hmaster` out 2: address-phase owner, value 1 or 2.
- `hmaster_data` out 2: data-phase owner, value 1 or 2.

## Operation
- Reset is applied on any `hclk` edge with `hresetn`=0, including mid-burst. Reset values:
  - the grant output for `DEFAULT_MASTER` is 1 and the other grant is 0;
  - `hmaster` = `hmaster_data` = `DEFAULT_MASTER`;
  - `beats_left` = 0; the state returns to OPEN.
- Accepted beat: an edge with `hready`=1 and `htrans` equal to NONSEQ or SEQ.
- Burst length `len` is decoded from `hburst` on a NONSEQ: SINGLE gives 1, INCR gives 1 (per beat), 4-beat gives 4, 8-beat gives 8, 16-beat gives 16.
- `beats_left` counter, 5 bits:
  - NONSEQ accepted: load `len`-1.
  - SEQ accepted with `beats_left`>0: decrement.
  - BUSY, IDLE and wait states: hold.
  - The counter never underflows.
- State machine (2 states):
  - OPEN: grant may change. Go to LOCKED when a NONSEQ is accepted with `len`>1.
  - LOCKED: grant frozen. Go to OPEN when the accepted SEQ brings `beats_left` to 0, on any edge where `hresp`≠OKAY, or on reset.
- INCR lock: in OPEN, the grant is also frozen while `hburst`=INCR, `htrans` is NONSEQ, SEQ or BUSY, and the request of the `hmaster` master is 1.
- Arbitration runs on an edge with `hready`=1, state OPEN (after the transitions above, so the last beat of a burst re-arbitrates) and no INCR lock:
  - no request: grant `DEFAULT_MASTER`;
  - one request: grant that master;
  - both requesting, `RR_EN`=1: grant the master other than `hmaster`;
  - both requesting, `RR_EN`=0: grant master 1.
- `hready`=0 freezes the grants, `hmaster`, `hmaster_data` and `beats_left`. The exception is the `hresp`≠OKAY exit to OPEN.
- Exactly one grant is 1 at every cycle.

## Timing
- Grants are registered. A request seen at edge E with arbitration allowed gives a grant visible after E.
- `hmaster` takes the index of the granted master on each edge with `hready`=1. A master therefore drives its first NONSEQ one cycle after its grant rises.
- `hmaster_data` takes the value of `hmaster` on each edge with `hready`=1, so it lags `hmaster` by one accepted transfer.
- Handover at the end of a burst: the grant changes on the edge of the final SEQ. The new master owns the address phase from the next `hready` edge, while the old master keeps the data phase for one transfer.
- On a simultaneous final beat and `hresp`≠OKAY, the state exits to OPEN once; no double transition occurs.

## Test plan
- Reset with `DEFAULT_MASTER`=1: after the reset edges, `hgrant_m1`=1, `hgrant_m2`=0, `hmaster`=1, `hmaster_data`=1. Hold `hresetn`=0 during an active burst: the same values appear one edge later.
- `hbusreq_m2`=1 alone, `hready`=1:
  - `hgrant_m2`=1 one cycle later;
  - `hmaster`=2 one cycle after that;
  - `hmaster_data`=2 after the following edge.
- Both masters requesting, SINGLE NONSEQ transfers, `RR_EN`=1: grants alternate 1,2,1,2 on successive transfers. With `RR_EN`=0, master 1 holds the grant throughout.
- Master 1 INCR4 with `hbusreq_m2`=1 and two `hready`=0 wait states on beat 2: `hgrant_m1` stays 1 through NONSEQ plus SEQ×3, then `hgrant_m2` rises on the edge of the 4th beat.
- Master 1 INCR8 with `hresp`=01 (ERROR) on beat 3: the state returns to OPEN, and `hgrant_m2` rises on the next `hready`=1 edge.
- INCR undefined-length by master 1 with `hbusreq_m1`=1 and `hbusreq_m2`=1:
  - the grant stays with master 1 for 6 beats;
  - dropping `hbusreq_m1` moves the grant to master 2 at the next `hready` edge.
